// File: rtl/klc_pkg.sv
// Shared types and sizing helpers for kernel_launch_ctrl.
// The watchdog counter width is derived from the configured timeout limit.
package klc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } klc_state_e;

  localparam int KLC_TIMEOUT_CY = 1024;

  function automatic int klc_cnt_w(input int timeout_cy);
    return $clog2(timeout_cy) + 1;
  endfunction

  localparam int KLC_CNT_W = klc_cnt_w(KLC_TIMEOUT_CY);

endpackage

// File: rtl/kernel_launch_ctrl_if.sv
// Bundle between host/kernel environment (master) and the launch controller (slave).
// Handshake: a transfer happens on a posedge where valid and ready are both high; a
// valid source holds valid and data stable until that edge, and ready never waits on valid.
interface kernel_launch_ctrl_if #(
  parameter int ARG_W = 1,
  parameter int RES_W = 2
);
  import klc_pkg::*;

  logic             arg_valid;
  logic             arg_ready;
  logic [ARG_W-1:0] arg_data;
  logic             k_r_enable;
  logic [ARG_W-1:0] k_init;
  logic             k_w_enable;
  logic [RES_W-1:0] k_result;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             res_timeout;
  logic             busy;
  klc_state_e       dbg_state;

  modport master (
    output arg_valid, arg_data, res_ready, k_w_enable, k_result,
    input  arg_ready, k_r_enable, k_init, res_valid, res_data, res_timeout, busy, dbg_state
  );

  modport slave (
    input  arg_valid, arg_data, res_ready, k_w_enable, k_result,
    output arg_ready, k_r_enable, k_init, res_valid, res_data, res_timeout, busy, dbg_state
  );

endinterface

// File: rtl/klc_rise_det.sv
// Registered 0->1 detector: o_rise is high while i_d is high and was low last cycle.
module klc_rise_det (
  input  logic clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (i_clr) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Drives one HLS kernel run per accepted argument and returns its result on a handshake.
// Optional watchdog: define KLC_TIMEOUT_EN to turn a stuck run into a timeout result.
module kernel_launch_ctrl
  import klc_pkg::*;
#(
  parameter int ARG_W      = 1,
  parameter int RES_W      = 2,
  parameter int TIMEOUT_CY = KLC_TIMEOUT_CY
) (
  input  logic                 clk,
  input  logic                 reset,
  kernel_launch_ctrl_if.slave  bus
);

  klc_state_e       r_state;
  logic             r_k_r_enable;
  logic [ARG_W-1:0] r_k_init;
  logic             r_res_valid;
  logic [RES_W-1:0] r_res_data;
  logic             w_rise;

  // History samples k_w_enable every cycle, so in LAUNCH it is loaded with the current
  // level and a done level already high on entering RUN is not mistaken for a new edge.
  klc_rise_det u_rise_det (
    .clk    (clk),
    .i_clr  (reset),
    .i_d    (bus.k_w_enable),
    .o_rise (w_rise)
  );

`ifdef KLC_TIMEOUT_EN
  localparam int CNT_W = klc_cnt_w(TIMEOUT_CY);
  logic [CNT_W-1:0] r_cnt;
  logic             r_res_timeout;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_k_r_enable  <= 1'b0;
      r_k_init      <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
`ifdef KLC_TIMEOUT_EN
      r_cnt         <= '0;
      r_res_timeout <= 1'b0;
`endif
    end else begin
      r_k_r_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.arg_valid) begin
            r_k_init     <= bus.arg_data;
            r_k_r_enable <= 1'b1;
            r_state      <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef KLC_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= RUN;
        end
        RUN: begin
          if (w_rise) begin
            r_res_data    <= bus.k_result;
`ifdef KLC_TIMEOUT_EN
            r_res_timeout <= 1'b0;
`endif
            r_res_valid   <= 1'b1;
            r_state       <= HOLD;
          end
`ifdef KLC_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CY - 1)) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.arg_ready  = (r_state == IDLE) & ~reset;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;
  assign bus.k_r_enable = r_k_r_enable;
  assign bus.k_init     = r_k_init;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
`ifdef KLC_TIMEOUT_EN
  assign bus.res_timeout = r_res_timeout;
`else
  // No watchdog in this build: the limit only matters as a sanity bound, flag is always 0.
  assign bus.res_timeout = (TIMEOUT_CY < 0);
`endif

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed bench for kernel_launch_ctrl with a behavioural kernel stub
// (result = init ? 3 : 2, done 5 cycles after the start pulse).
module tb_kernel_launch_ctrl;
  import klc_pkg::*;

  localparam int ARG_W = 1;
  localparam int RES_W = 2;
  localparam int TCY   = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  kernel_launch_ctrl_if #(.ARG_W(ARG_W), .RES_W(RES_W)) bus ();

  kernel_launch_ctrl #(.ARG_W(ARG_W), .RES_W(RES_W), .TIMEOUT_CY(TCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not complete, got stuck, required finish");
    $fatal(1, "global timeout");
  end

  // kernel stub
  logic stub_keep  = 1'b0;
  logic stub_never = 1'b0;
  logic stub_drop  = 1'b0;
  logic stub_w     = 1'b0;
  int   stub_cnt   = 0;

  assign bus.k_w_enable = stub_w;
  assign bus.k_result   = bus.k_init[0] ? 2'd3 : 2'd2;

  always @(negedge clk) begin
    if (stub_cnt != 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_keep && stub_cnt == 2) stub_w = 1'b0;
      if (stub_cnt == 0 && !stub_never) begin
        stub_w    = 1'b1;
        stub_drop = !stub_keep;
      end
    end else if (stub_drop) begin
      stub_w    = 1'b0;
      stub_drop = 1'b0;
    end
    if (bus.k_r_enable) begin
      stub_cnt  = 5;
      stub_drop = 1'b0;
      if (!stub_keep) stub_w = 1'b0;
    end
  end

  // start-pulse monitor
  int n_pulses = 0;
  int exp_pulses = 0;
  always @(posedge clk) if (bus.k_r_enable) n_pulses = n_pulses + 1;

  // scoreboard
  logic [RES_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  // driver tasks (all start and end on a negedge)
  task automatic send_arg(input logic [ARG_W-1:0] d);
    int n;
    n = 0;
    bus.arg_data  = d;
    bus.arg_valid = 1'b1;
    while (!bus.arg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("arg_ready_seen", {31'd0, bus.arg_ready}, 1);
    @(negedge clk);
    bus.arg_valid = 1'b0;
    exp_pulses++;
    exp_q.push_back(d[0] ? 2'd3 : 2'd2);
    check_eq("launch_r_enable", {31'd0, bus.k_r_enable}, 1);
    check_eq("launch_k_init", {31'd0, bus.k_init}, {31'd0, d});
    check_eq("launch_arg_ready", {31'd0, bus.arg_ready}, 0);
    check_eq("launch_busy", {31'd0, bus.busy}, 1);
  endtask

  task automatic wait_res(input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("res_valid_seen", {31'd0, bus.res_valid}, 1);
    check_eq("start_to_valid", lat, exp_lat);
  endtask

  task automatic check_res();
    logic [RES_W-1:0] e;
    e = exp_q.pop_front();
    check_eq("res_data", {30'd0, bus.res_data}, {30'd0, e});
    check_eq("res_timeout", {31'd0, bus.res_timeout}, 0);
    check_eq("hold_arg_ready", {31'd0, bus.arg_ready}, 0);
    check_eq("hold_state", {30'd0, bus.dbg_state}, {30'd0, HOLD});
  endtask

  task automatic finish_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_eq("post_hs_res_valid", {31'd0, bus.res_valid}, 0);
    check_eq("post_hs_arg_ready", {31'd0, bus.arg_ready}, 1);
    check_eq("post_hs_busy", {31'd0, bus.busy}, 0);
  endtask

  initial begin
    logic saw_valid;
    bus.arg_valid = 1'b0;
    bus.arg_data  = '0;
    bus.res_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_arg_ready", {31'd0, bus.arg_ready}, 0);
    check_eq("rst_r_enable", {31'd0, bus.k_r_enable}, 0);
    check_eq("rst_k_init", {31'd0, bus.k_init}, 0);
    check_eq("rst_res_valid", {31'd0, bus.res_valid}, 0);
    check_eq("rst_res_data", {30'd0, bus.res_data}, 0);
    check_eq("rst_res_timeout", {31'd0, bus.res_timeout}, 0);
    check_eq("rst_busy", {31'd0, bus.busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_arg_ready", {31'd0, bus.arg_ready}, 1);
    check_eq("idle_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});

    // 1: arg 1, consumer always ready
    send_arg(1'b1);
    wait_res(6);
    check_res();
    finish_res();
    check_eq("t1_pulses", n_pulses, exp_pulses);

    // 2: arg 0
    repeat (2) @(negedge clk);
    send_arg(1'b0);
    wait_res(6);
    check_res();
    finish_res();

    // 3: consumer stalls; result stays put and a new argument is refused
    bus.res_ready = 1'b0;
    send_arg(1'b1);
    wait_res(6);
    check_res();
    bus.arg_valid = 1'b1;
    bus.arg_data  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_res_valid", {31'd0, bus.res_valid}, 1);
      check_eq("stall_res_data", {30'd0, bus.res_data}, 3);
      check_eq("stall_arg_ready", {31'd0, bus.arg_ready}, 0);
    end
    bus.arg_valid = 1'b0;
    check_eq("stall_pulses", n_pulses, exp_pulses);
    finish_res();

    // 4: done level left high between runs; only a fresh rising edge counts
    stub_keep = 1'b1;
    send_arg(1'b1);
    wait_res(6);
    check_res();
    finish_res();
    repeat (3) @(negedge clk);
    check_eq("keep_w_high", {31'd0, stub_w}, 1);
    send_arg(1'b0);
    wait_res(6);
    check_res();
    finish_res();
    stub_keep = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset two cycles into RUN
    send_arg(1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_busy", {31'd0, bus.busy}, 0);
    check_eq("mid_rst_res_valid", {31'd0, bus.res_valid}, 0);
    check_eq("mid_rst_arg_ready", {31'd0, bus.arg_ready}, 0);
    check_eq("mid_rst_k_init", {31'd0, bus.k_init}, 0);
    reset = 1'b0;
    exp_q.delete();
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid) saw_valid = 1'b1;
    end
    check_eq("post_rst_no_result", {31'd0, saw_valid}, 0);
    check_eq("post_rst_pulses", n_pulses, exp_pulses);
    check_eq("post_rst_arg_ready", {31'd0, bus.arg_ready}, 1);

    // 6: kernel never finishes
    stub_never = 1'b1;
    send_arg(1'b1);
    void'(exp_q.pop_front());
`ifdef KLC_TIMEOUT_EN
    wait_res(TCY + 1);
    check_eq("tmo_res_data", {30'd0, bus.res_data}, 0);
    check_eq("tmo_res_timeout", {31'd0, bus.res_timeout}, 1);
    finish_res();
`else
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.res_valid) saw_valid = 1'b1;
    end
    check_eq("hang_no_result", {31'd0, saw_valid}, 0);
    check_eq("hang_busy", {31'd0, bus.busy}, 1);
    check_eq("hang_state", {30'd0, bus.dbg_state}, {30'd0, RUN});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("hang_recover_ready", {31'd0, bus.arg_ready}, 1);
`endif
    stub_never = 1'b0;
    check_eq("final_pulses", n_pulses, exp_pulses);
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
